// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential adder/subtractor: operation mode
// encodings and the control FSM state type.
package seq_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_addsub_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry slice.
// Ports:
//   a, b  CHUNK-bit addends
//   cin   carry into bit 0
//   sum   CHUNK-bit slice sum
//   cout  carry out of bit CHUNK-1
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] carry;

  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[CHUNK];
  end

endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock,
// carry chained between slices through a register. Start/Ready/Done handshake.
// Ports:
//   Clk          clock, all state on posedge
//   Rst_n        synchronous active-low reset
//   Start        request, accepted on an edge where Ready=1
//   Mode         0 = In1+In2+Cin, 1 = In1-In2-Cin
//   In1, In2     operands, latched on accept
//   Cin          carry-in / borrow-in, latched on accept
//   Ready        unit can accept Start this cycle
//   Done         one-cycle pulse when the result outputs were updated
//   Sum          result (modulo 2^WIDTH)
//   Cout         carry out of MSB; in subtract mode 1 = no borrow
//   Ovf          two's complement overflow
//   Zero         Sum == 0
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Mode,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Cin,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      lo;
  logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;
  logic             accept, last;
  logic             ovf_next;

  // Control FSM: next state and handshake outputs
  always_comb begin
    state_next = state;
    Ready      = 1'b1;
    Done       = 1'b0;
    case (state)
      ST_IDLE: if (Start) state_next = ST_RUN;
      ST_RUN: begin
        Ready = 1'b0;
        if (cnt_q == LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        Done       = 1'b1;
        state_next = Start ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept = Start & Ready;
  assign last   = (state == ST_RUN) && (cnt_q == LAST);
  assign lo     = 32'(cnt_q) * CHUNK;

  // The single slice adder walks across the latched operands, one chunk per RUN cycle
  always_comb begin
    slice_a  = a_q[lo +: CHUNK];
    slice_b  = b_q[lo +: CHUNK];
    acc_next = acc_q;
    acc_next[lo +: CHUNK] = slice_sum;
  end

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (c_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // b_q already holds the inverted subtrahend, so one rule covers add and sub
  assign ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      Zero  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q   <= In1;
        b_q   <= (Mode == MODE_SUB) ? ~In2 : In2;
        c_q   <= (Mode == MODE_SUB) ? ~Cin : Cin;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state == ST_RUN) begin
        acc_q <= acc_next;
        c_q   <= slice_cout;
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (last) begin
          Sum  <= acc_next;
          Cout <= slice_cout;
          Ovf  <= ovf_next;
          Zero <= (acc_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Testbench for seq_addsub: WIDTH=32 with CHUNK=8 (index 0) and CHUNK=32 (index 1).
module tb_seq_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v [2];
  logic        mode_v  [2];
  logic        cin_v   [2];
  logic        ready_v [2];
  logic        done_v  [2];
  logic        cout_v  [2];
  logic        ovf_v   [2];
  logic        zero_v  [2];
  logic [31:0] in1_v   [2];
  logic [31:0] in2_v   [2];
  logic [31:0] sum_v   [2];

  seq_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start_v[0]), .Mode(mode_v[0]),
    .In1(in1_v[0]), .In2(in2_v[0]), .Cin(cin_v[0]), .Ready(ready_v[0]),
    .Done(done_v[0]), .Sum(sum_v[0]), .Cout(cout_v[0]), .Ovf(ovf_v[0]),
    .Zero(zero_v[0])
  );

  seq_addsub #(.WIDTH(32), .CHUNK(32)) dut_w (
    .Clk(clk), .Rst_n(rst_n), .Start(start_v[1]), .Mode(mode_v[1]),
    .In1(in1_v[1]), .In2(in2_v[1]), .Cin(cin_v[1]), .Ready(ready_v[1]),
    .Done(done_v[1]), .Sum(sum_v[1]), .Cout(cout_v[1]), .Ovf(ovf_v[1]),
    .Zero(zero_v[1])
  );

  // res packs {sum, cout, ovf, zero}
  typedef struct packed {
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [34:0] res;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow
  function automatic logic [34:0] model(input logic m, input logic [31:0] a,
                                       input logic [31:0] b, input logic ci);
    logic [31:0] s;
    logic        co, ov;
    longint      sr;
    if (!m) begin
      logic [32:0] r;
      r  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      s  = r[31:0];
      co = r[32];
      sr = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    end else begin
      s  = a - b - {31'd0, ci};
      co = ({1'b0, a} >= ({1'b0, b} + {32'd0, ci}));
      sr = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {s, co, ov, (s == 32'd0)};
  endfunction

  function automatic logic [34:0] outs(input int w);
    return {sum_v[w], cout_v[w], ovf_v[w], zero_v[w]};
  endfunction

  task automatic run_op(input int w, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic ci,
                        input logic [34:0] exp, input string tag);
    int          nch;
    int          lat;
    int          nd;
    int          waitc;
    logic [34:0] got;
    nch   = (w == 0) ? 4 : 1;
    lat   = 0;
    nd    = 0;
    waitc = 0;
    got   = '0;
    while (!ready_v[w] && waitc < 20) begin
      tick();
      waitc++;
    end
    check({tag, " ready"}, 64'(ready_v[w]), 64'd1);
    mode_v[w]  = m;
    in1_v[w]   = a;
    in2_v[w]   = b;
    cin_v[w]   = ci;
    start_v[w] = 1'b1;
    tick();
    start_v[w] = 1'b0;
    // operand changes after accept must not disturb the running op
    in1_v[w]  = $urandom;
    in2_v[w]  = $urandom;
    mode_v[w] = ~m;
    cin_v[w]  = ~ci;
    for (int i = 1; i <= nch + 3; i++) begin
      tick();
      if (done_v[w]) begin
        nd++;
        if (nd == 1) begin
          lat = i;
          got = outs(w);
        end
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(nch));
    check({tag, " done count"}, 64'(nd), 64'd1);
    check({tag, " result"}, 64'(got), 64'(exp));
  endtask

  initial begin
    int          lat;
    int          nd;
    logic [31:0] ra, rb;
    logic        rm, rc;

    vecs[0] = '{mode: 1'b0, a: 32'hFFFFFFFF, b: 32'h00000001, cin: 1'b0, res: {32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[1] = '{mode: 1'b0, a: 32'h7FFFFFFF, b: 32'h00000001, cin: 1'b0, res: {32'h80000000, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{mode: 1'b1, a: 32'h00000005, b: 32'h00000007, cin: 1'b0, res: {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{mode: 1'b1, a: 32'h80000000, b: 32'h00000001, cin: 1'b0, res: {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
    vecs[4] = '{mode: 1'b1, a: 32'h00000001, b: 32'h00000001, cin: 1'b1, res: {32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{mode: 1'b0, a: 32'hAAAAAAAA, b: 32'h55555555, cin: 1'b1, res: {32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[6] = '{mode: 1'b1, a: 32'h00000000, b: 32'h00000000, cin: 1'b0, res: {32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[7] = '{mode: 1'b0, a: 32'h80000000, b: 32'h80000000, cin: 1'b0, res: {32'h00000000, 1'b1, 1'b1, 1'b1}};
    vecs[8] = '{mode: 1'b0, a: 32'h12345678, b: 32'h87654321, cin: 1'b0, res: {32'h99999999, 1'b0, 1'b0, 1'b0}};

    rst_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      start_v[w] = 1'b0;
      mode_v[w]  = 1'b0;
      cin_v[w]   = 1'b0;
      in1_v[w]   = '0;
      in2_v[w]   = '0;
    end

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    for (int w = 0; w < 2; w++)
      check($sformatf("reset state dut%0d", w),
            64'({ready_v[w], done_v[w], outs(w)}), 64'({1'b1, 1'b0, 35'd0}));

    // Directed table on both configurations
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 9; i++)
        run_op(w, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res,
               $sformatf("vec%0d dut%0d", i, w));

    // Back-to-back issue: Start held through the Done cycle
    mode_v[0]  = 1'b0;
    in1_v[0]   = 32'hAAAAAAAA;
    in2_v[0]   = 32'h55555555;
    cin_v[0]   = 1'b1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    nd = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (done_v[0]) nd++;
    end
    check("b2b early done", 64'(nd), 64'd0);
    in1_v[0]   = 32'h12345678;
    in2_v[0]   = 32'h87654321;
    cin_v[0]   = 1'b0;
    start_v[0] = 1'b1;
    tick();
    check("b2b first done", 64'(done_v[0]), 64'd1);
    check("b2b first result", 64'(outs(0)), 64'({32'h00000000, 1'b1, 1'b0, 1'b1}));
    tick();
    check("b2b second accepted", 64'(ready_v[0]), 64'd0);
    start_v[0] = 1'b0;
    lat = 0;
    nd  = 0;
    for (int i = 1; i <= 8; i++) begin
      // stray Start pulses while busy must be ignored
      start_v[0] = (i == 1 || i == 3);
      in1_v[0]   = 32'hFFFFFFFF;
      tick();
      start_v[0] = 1'b0;
      if (done_v[0]) begin
        nd++;
        if (nd == 1) lat = i;
      end
      if (i == 2) check("b2b result held in RUN", 64'(outs(0)), 64'({32'h00000000, 1'b1, 1'b0, 1'b1}));
    end
    check("b2b second latency", 64'(lat), 64'd4);
    check("b2b second done count", 64'(nd), 64'd1);
    check("b2b second result", 64'(outs(0)), 64'({32'h99999999, 1'b0, 1'b0, 1'b0}));

    // Reset on the second RUN edge aborts the op
    mode_v[0]  = 1'b0;
    in1_v[0]   = 32'hFFFFFFFF;
    in2_v[0]   = 32'h00000001;
    cin_v[0]   = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrun reset state", 64'({ready_v[0], done_v[0], outs(0)}), 64'({1'b1, 1'b0, 35'd0}));
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_v[0]) nd++;
    end
    check("midrun reset no done", 64'(nd), 64'd0);
    run_op(0, 1'b0, 32'h00000001, 32'h00000001, 1'b0, {32'h00000002, 1'b0, 1'b0, 1'b0}, "after reset");

    // Random operations against the reference model
    for (int w = 0; w < 2; w++)
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom;
        rb = $urandom;
        rm = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
        run_op(w, rm, ra, rb, rc, model(rm, ra, rb, rc), $sformatf("rand%0d dut%0d", n, w));
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
